// File: rtl/onchip_mem_s2_arbiter_pkg.sv
// Shared types and defaults for the on-chip memory s2 arbiter slice.
package onchip_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 14;
    localparam int unsigned DEF_DATA_W  = 64;
    localparam int unsigned DEF_BE_W    = 8;
    localparam int unsigned MAX_NUM_REQ = 8;
    localparam int unsigned REQ_ID_W    = $clog2(MAX_NUM_REQ);

    // Requester ID, sized for the largest legal NUM_REQ so every arbiter shares one type
    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic req_id_t rr_next(input req_id_t id, input int unsigned num_req);
        return (32'(id) + 32'd1 >= num_req) ? '0 : id + req_id_t'(1);
    endfunction

endpackage

// File: rtl/onchip_mem_s2_arbiter_if.sv
// Fabric-side command/response bus plus the exported onchip_memory_s2 conduit.
interface onchip_mem_s2_arbiter_if
    import onchip_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned BE_W    = DEF_BE_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_writedata;
    logic [NUM_REQ*BE_W-1:0]   req_byteenable;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_readdata;
    logic [ADDR_W-1:0]         s2_address;
    logic                      s2_chipselect;
    logic                      s2_clken;
    logic                      s2_write;
    logic [DATA_W-1:0]         s2_writedata;
    logic [BE_W-1:0]           s2_byteenable;
    logic [DATA_W-1:0]         s2_readdata;

    modport slave (
        input  req_valid, req_write, req_lock, req_address, req_writedata, req_byteenable,
        input  s2_readdata,
        output req_ready, rsp_valid, rsp_readdata,
        output s2_address, s2_chipselect, s2_clken, s2_write, s2_writedata, s2_byteenable
    );

    modport master (
        output req_valid, req_write, req_lock, req_address, req_writedata, req_byteenable,
        output s2_readdata,
        input  req_ready, rsp_valid, rsp_readdata,
        input  s2_address, s2_chipselect, s2_clken, s2_write, s2_writedata, s2_byteenable
    );

endinterface

// File: rtl/onchip_mem_s2_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module onchip_arb_rr_pick
    import onchip_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output req_id_t            id_c
);

    logic found;

    always_comb begin
        grant_c = '0;
        id_c    = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && ((32'(ptr) + i) % NUM_REQ == j)) begin
                    found      = 1'b1;
                    grant_c[j] = 1'b1;
                    id_c       = req_id_t'(j);
                end
            end
        end
    end

endmodule

// File: rtl/onchip_mem_s2_arbiter.sv
// Round-robin arbiter for the 64-bit s2 port of the on-chip memory, with read-tag return routing.
// Optional burst lock enabled by defining ONCHIP_ARB_BURST_LOCK_EN.
module onchip_mem_s2_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned BE_W     = DEF_BE_W,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    onchip_mem_s2_arbiter_if.slave  bus,
    output logic                    busy
);

    arb_state_t          state_q, state_d;
    req_id_t             rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  pick_req_c, grant_c, rsp_valid_c;
    req_id_t             win_id_c;
    logic                accept_c;
    logic                win_write_c;
    logic [ADDR_W-1:0]   win_addr_c;
    logic [DATA_W-1:0]   win_data_c;
    logic [BE_W-1:0]     win_be_c;

    logic                clken_q, cs_q, write_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [RD_LAT:0]     tag_v_q;
    req_id_t [RD_LAT:0]  tag_id_q;

`ifdef ONCHIP_ARB_BURST_LOCK_EN
    localparam int unsigned LOCK_CNT_W = $clog2(MAX_LOCK + 1);
    req_id_t                owner_q, owner_d;
    logic [LOCK_CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]     owner_mask_c;
    logic                   win_lock_c;

    always_comb begin
        owner_mask_c = '0;
        win_lock_c   = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            owner_mask_c[j] = (owner_q == req_id_t'(j));
            if (grant_c[j]) win_lock_c = bus.req_lock[j];
        end
    end

    // While locked only the owner may compete, even if it is momentarily idle
    assign pick_req_c = !clken_q ? '0 :
                        (state_q == LOCKED) ? (bus.req_valid & owner_mask_c) : bus.req_valid;
`else
    logic unused_lock;
    assign unused_lock = ^{bus.req_lock, MAX_LOCK};
    // Arbitration starts one cycle after reset release, together with clken
    assign pick_req_c  = clken_q ? bus.req_valid : '0;
`endif

    onchip_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (pick_req_c),
        .ptr     (rr_ptr_q),
        .grant_c (grant_c),
        .id_c    (win_id_c)
    );

    assign accept_c      = |grant_c;
    assign bus.req_ready = grant_c;

    // Winner's command slice
    always_comb begin
        win_write_c = 1'b0;
        win_addr_c  = '0;
        win_data_c  = '0;
        win_be_c    = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (grant_c[j]) begin
                win_write_c = bus.req_write[j];
                win_addr_c  = bus.req_address[j*ADDR_W +: ADDR_W];
                win_data_c  = bus.req_writedata[j*DATA_W +: DATA_W];
                win_be_c    = bus.req_byteenable[j*BE_W +: BE_W];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
`ifdef ONCHIP_ARB_BURST_LOCK_EN
            owner_q    <= '0;
            lock_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef ONCHIP_ARB_BURST_LOCK_EN
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
`ifdef ONCHIP_ARB_BURST_LOCK_EN
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
`endif
        if (accept_c) rr_ptr_d = rr_next(win_id_c, NUM_REQ);
`ifdef ONCHIP_ARB_BURST_LOCK_EN
        // lock_cnt counts grants in the burst, including the one that opened it
        unique case (state_q)
            ARB: begin
                if (accept_c && win_lock_c) begin
                    state_d    = LOCKED;
                    owner_d    = win_id_c;
                    lock_cnt_d = LOCK_CNT_W'(1);
                end
            end
            LOCKED: begin
                if (accept_c) begin
                    if (!win_lock_c || (lock_cnt_q >= LOCK_CNT_W'(MAX_LOCK - 1)))
                        state_d = ARB;
                    else
                        lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
                end
            end
            default: state_d = ARB;
        endcase
`else
        state_d = ARB;
`endif
    end

    // s2 command registers and read-tag pipeline; tag stage RD_LAT lines up with s2_readdata
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clken_q  <= 1'b0;
            cs_q     <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            clken_q  <= 1'b1;
            cs_q     <= accept_c;
            tag_v_q  <= {tag_v_q[RD_LAT-1:0], accept_c & ~win_write_c};
            tag_id_q <= {tag_id_q[RD_LAT-1:0], win_id_c};
            if (accept_c) begin
                write_q <= win_write_c;
                addr_q  <= win_addr_c;
                wdata_q <= win_data_c;
                be_q    <= win_be_c;
            end
        end
    end

    always_comb begin
        rsp_valid_c = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++)
            rsp_valid_c[j] = tag_v_q[RD_LAT] && (tag_id_q[RD_LAT] == req_id_t'(j));
    end

    assign bus.rsp_valid     = rsp_valid_c;
    assign bus.rsp_readdata  = tag_v_q[RD_LAT] ? bus.s2_readdata : '0;
    assign bus.s2_address    = addr_q;
    assign bus.s2_chipselect = cs_q;
    assign bus.s2_clken      = clken_q;
    assign bus.s2_write      = write_q;
    assign bus.s2_writedata  = wdata_q;
    assign bus.s2_byteenable = be_q;
    assign busy              = cs_q | (|tag_v_q);

endmodule

// File: tb/tb_onchip_mem_s2_arbiter.sv
// Directed bench for onchip_mem_s2_arbiter with a 2-cycle-latency s2 memory model.
module tb_onchip_mem_s2_arbiter;
    import onchip_arb_pkg::*;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned BE_W     = 8;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned MAX_LOCK = 16;

    logic clk_clk = 1'b0;
    logic reset_reset_n;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk_clk = ~clk_clk;

    onchip_mem_s2_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

    onchip_mem_s2_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus.slave),
        .busy          (busy)
    );

    // Background contents for locations never written
    function automatic logic [63:0] pat(input logic [13:0] a);
        return {16'hC0DE, 2'b00, a, 16'h5A5A, 2'b11, ~a};
    endfunction

    // Memory: address/control sampled on the edge, data out after a second register
    logic [DATA_W-1:0] mem [int];
    logic [DATA_W-1:0] rd_pipe;
    always @(posedge clk_clk) begin : mem_model
        logic [DATA_W-1:0] cur;
        int a;
        a   = int'(bus.s2_address);
        cur = mem.exists(a) ? mem[a] : pat(bus.s2_address);
        if (bus.s2_chipselect && bus.s2_write) begin
            for (int b = 0; b < int'(BE_W); b++)
                if (bus.s2_byteenable[b]) cur[b*8 +: 8] = bus.s2_writedata[b*8 +: 8];
            mem[a] = cur;
        end
        if (bus.s2_chipselect && !bus.s2_write) rd_pipe <= cur;
        bus.s2_readdata <= rd_pipe;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;
    endtask

    task automatic issue(input int r, input logic wr, input logic [13:0] a,
                         input logic [63:0] d, input logic [7:0] be);
        @(negedge clk_clk);
        bus.req_write[r]                      = wr;
        bus.req_address[r*ADDR_W +: ADDR_W]   = a;
        bus.req_writedata[r*DATA_W +: DATA_W] = d;
        bus.req_byteenable[r*BE_W +: BE_W]    = be;
        bus.req_valid[r]                      = 1'b1;
        #1;
        chk("ready", 64'(bus.req_ready), 64'(1 << r));
        @(posedge clk_clk);
        #1;
        bus.req_valid[r] = 1'b0;
        chk("s2_cs", 64'(bus.s2_chipselect), 64'd1);
        chk("s2_write", 64'(bus.s2_write), 64'(wr));
        chk("s2_addr", 64'(bus.s2_address), 64'(a));
        if (wr) begin
            chk("s2_wdata", bus.s2_writedata, d);
            chk("s2_be", 64'(bus.s2_byteenable), 64'(be));
        end
    endtask

    task automatic read_chk(input int r, input logic [13:0] a, input logic [63:0] exp, input string tag);
        int n;
        n = 0;
        issue(r, 1'b0, a, 64'd0, 8'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        while (bus.rsp_valid == '0 && n < 8) begin
            @(posedge clk_clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(RD_LAT));
        chk({tag, "_id"}, 64'(bus.rsp_valid), 64'(1 << r));
        chk({tag, "_data"}, bus.rsp_readdata, exp);
        @(posedge clk_clk);
        #1;
        chk({tag, "_rsp_off"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int spur;
        bus.req_valid      = '0;
        bus.req_write      = '0;
        bus.req_lock       = '0;
        bus.req_address    = '0;
        bus.req_writedata  = '0;
        bus.req_byteenable = '0;
        reset_reset_n      = 1'b1;
        #1 reset_reset_n   = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", bus.rsp_readdata, 64'd0);
        chk("rst_cs", 64'(bus.s2_chipselect), 64'd0);
        chk("rst_write", 64'(bus.s2_write), 64'd0);
        chk("rst_clken", 64'(bus.s2_clken), 64'd0);
        chk("rst_addr", 64'(bus.s2_address), 64'd0);
        chk("rst_wdata", bus.s2_writedata, 64'd0);
        chk("rst_be", 64'(bus.s2_byteenable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        apply_reset();
        chk("idle_clken", 64'(bus.s2_clken), 64'd1);
        chk("idle_cs", 64'(bus.s2_chipselect), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(bus.req_ready), 64'd0);

        // Write then back-to-back read of the same word from requester 0
        issue(0, 1'b1, 14'h0010, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        read_chk(0, 14'h0010, 64'hDEADBEEF_CAFEF00D, "raw");

        // Partial byteenable over all-ones
        issue(1, 1'b1, 14'h0020, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
        issue(1, 1'b1, 14'h0020, 64'h12345678_9ABCDEF0, 8'h0F);
        read_chk(1, 14'h0020, 64'hFFFFFFFF_9ABCDEF0, "be");
        chk("addr_hold", 64'(bus.s2_address), 64'h20);
        chk("cs_idle", 64'(bus.s2_chipselect), 64'd0);

        // All four reading continuously from rr_ptr=0; responses trail grants by RD_LAT+1
        apply_reset();
        @(negedge clk_clk);
        for (int i = 0; i < 4; i++) begin
            bus.req_write[i]                      = 1'b0;
            bus.req_address[i*ADDR_W +: ADDR_W]   = 14'(14'h100 + i);
            bus.req_valid[i]                      = 1'b1;
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 5) bus.req_valid = '0;
            #1;
            chk("rr_grant", 64'(bus.req_ready), (k < 5) ? 64'(1 << (k % 4)) : 64'd0);
            chk("rr_rsp", 64'(bus.rsp_valid), (k >= 3 && k < 8) ? 64'(1 << ((k - 3) % 4)) : 64'd0);
            if (k >= 3 && k < 8)
                chk("rr_data", bus.rsp_readdata, pat(14'(14'h100 + (k - 3) % 4)));
            @(negedge clk_clk);
        end

        // Reset with two reads in flight
        apply_reset();
        @(negedge clk_clk);
        bus.req_address[0 +: ADDR_W]      = 14'h0030;
        bus.req_address[ADDR_W +: ADDR_W] = 14'h0031;
        bus.req_valid = 4'b0011;
        @(posedge clk_clk);
        @(posedge clk_clk);
        #1;
        bus.req_valid = '0;
        chk("busy_inflight", 64'(busy), 64'd1);
        reset_reset_n = 1'b0;
        #1;
        chk("midrst_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cs", 64'(bus.s2_chipselect), 64'd0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        spur = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_clk);
            #1;
            if (bus.rsp_valid != '0) spur++;
        end
        chk("midrst_no_rsp", 64'(spur), 64'd0);
        @(negedge clk_clk);
        bus.req_valid = 4'b1111;
        #1;
        chk("midrst_ptr", 64'(bus.req_ready), 64'd1);
        bus.req_valid = '0;

        // Requester 2 asks for lock while 0 and 1 compete
        apply_reset();
        @(negedge clk_clk);
        bus.req_write   = '0;
        bus.req_lock    = 4'b0100;
        bus.req_valid   = 4'b0111;
        for (int k = 0; k < 19; k++) begin
            logic [63:0] exp;
`ifdef ONCHIP_ARB_BURST_LOCK_EN
            exp = (k == 0) ? 64'd1 : (k == 1) ? 64'd2 : (k < 18) ? 64'd4 : 64'd1;
`else
            exp = 64'(1 << (k % 3));
`endif
            #1;
            chk("lock_grant", 64'(bus.req_ready), exp);
            @(negedge clk_clk);
        end
        bus.req_valid = '0;
        bus.req_lock  = '0;
        repeat (4) @(posedge clk_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
